// File: rtl/fcvt_s_x_pipe_if.sv
//==============================================================================
// Module      : fcvt_s_x_pipe_if
// Description : Operand/result handshake bundle for the integer-to-binary32
//               converter pipeline.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface fcvt_s_x_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         is_unsigned;
    logic [2:0]   rm;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  y;
    logic         nx;

    modport master (
        output in_valid, x, is_unsigned, rm, out_ready,
        input  in_ready, out_valid, y, nx
    );

    modport slave (
        input  in_valid, x, is_unsigned, rm, out_ready,
        output in_ready, out_valid, y, nx
    );
endinterface

`default_nettype wire

// File: rtl/fcvt_s_x_pipe.sv
//==============================================================================
// Module      : fcvt_s_x_pipe
// Description : Fixed-latency W-bit integer to IEEE-754 binary32 converter
//               with five rounding modes, inexact flag and global stall.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module fcvt_s_x_pipe #(
    parameter int W       = 32,
    parameter int LATENCY = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fcvt_s_x_pipe_if.slave bus
);
    // Magnitude is widened to at least 26 bits so the 24 kept bits, guard and
    // sticky slices always exist, even for narrow W.
    localparam int c_WE = (W > 26) ? W : 26;
    localparam int c_RD = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic w_adv;
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    logic         w_fs;
    logic [W-1:0] w_fm;
    assign w_fs = !bus.is_unsigned && bus.x[W-1];
    assign w_fm = w_fs ? -bus.x : bus.x;

    logic         w_bv;
    logic         w_bs;
    logic [W-1:0] w_bm;
    logic [2:0]   w_brm;

    // Deeper builds register sign/magnitude before normalise+round.
    if (LATENCY > 1) begin : g_front_reg
        logic         r_fv_q;
        logic         r_fs_q;
        logic [W-1:0] r_fm_q;
        logic [2:0]   r_frm_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_fv_q  <= 1'b0;
                r_fs_q  <= 1'b0;
                r_fm_q  <= '0;
                r_frm_q <= '0;
            end else if (w_adv) begin
                r_fv_q  <= bus.in_valid;
                r_fs_q  <= w_fs;
                r_fm_q  <= w_fm;
                r_frm_q <= bus.rm;
            end
        end

        assign w_bv  = r_fv_q;
        assign w_bs  = r_fs_q;
        assign w_bm  = r_fm_q;
        assign w_brm = r_frm_q;
    end else begin : g_front_comb
        assign w_bv  = bus.in_valid;
        assign w_bs  = w_fs;
        assign w_bm  = w_fm;
        assign w_brm = bus.rm;
    end

    logic [c_WE-1:0] w_mext;
    logic [c_WE-1:0] w_norm;
    logic [6:0]      w_lead;
    logic [23:0]     w_kept;
    logic            w_g;
    logic            w_st;
    logic            w_inc;
    logic            w_carry;
    logic            w_zero;
    logic [22:0]     w_mant;
    logic [7:0]      w_exp;
    logic [31:0]     w_y_d;
    logic            w_nx_d;

    assign w_mext = c_WE'(w_bm);

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < c_WE; i++) begin
            if (w_mext[i]) begin
                w_lead = 7'(i);
            end
        end
    end

    // Leading one lands on the MSB; a zero operand leaves the top bit clear.
    assign w_norm = w_mext << (7'(c_WE - 1) - w_lead);
    assign w_kept = w_norm[c_WE-1 -: 24];
    assign w_g    = w_norm[c_WE-25];
    assign w_st   = |w_norm[c_WE-26:0];
    assign w_zero = !w_kept[23];

    always_comb begin
        case (w_brm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = w_bs && (w_g || w_st);
            3'b011:  w_inc = !w_bs && (w_g || w_st);
            3'b100:  w_inc = w_g;
            default: w_inc = w_g && (w_st || w_kept[0]);
        endcase
    end

    // An all-ones fraction wraps to zero on increment, which is exactly 1.0
    // at the next exponent.
    assign w_carry = w_inc && (&w_kept[22:0]);
    assign w_mant  = w_kept[22:0] + {22'd0, w_inc};
    assign w_exp   = 8'd127 + {1'b0, w_lead} + {7'd0, w_carry};
    assign w_y_d   = w_zero ? 32'd0 : {w_bs, w_exp, w_mant};
    assign w_nx_d  = w_g || w_st;

    logic [c_RD-1:0]       r_vld_q;
    logic [c_RD-1:0]       r_nx_q;
    logic [c_RD-1:0][31:0] r_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q <= '0;
            r_nx_q  <= '0;
            r_y_q   <= '0;
        end else if (w_adv) begin
            r_vld_q[0] <= w_bv;
            r_y_q[0]   <= w_y_d;
            r_nx_q[0]  <= w_nx_d;
            for (int i = 1; i < c_RD; i++) begin
                r_vld_q[i] <= r_vld_q[i-1];
                r_y_q[i]   <= r_y_q[i-1];
                r_nx_q[i]  <= r_nx_q[i-1];
            end
        end
    end

    assign bus.out_valid = r_vld_q[c_RD-1];
    assign bus.y         = r_y_q[c_RD-1];
    assign bus.nx        = r_nx_q[c_RD-1];
endmodule

`default_nettype wire

// File: doc/fcvt_s_x_pipe.md
Name: fcvt_s_x_pipe

Overview:
- Parametrised, handshaked successor to the single-precision integer-to-float converter.
- Converts a W-bit integer to IEEE-754 binary32. Per operation it selects signed or unsigned input and one of five RISC-V rounding modes, and raises an inexact flag.
- Sits in the FPU issue path, serving fcvt.s.w, fcvt.s.wu and their wider variants.
- Fixed-latency pipeline with global stall under output backpressure.

Parameters:
- W, 32, integer input width; legal range 8..64.
- LATENCY, 3, cycles from accepted input to out_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  converter can accept an operand this cycle.
- x  in  W  integer operand.
- is_unsigned  in  1  1 treats x as unsigned; 0 treats x as two's complement.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  32  binary32 result.
- nx  out  1  inexact flag; valid with y.

Behaviour:
- Reset (rst high at a clock edge):
  - All stage valids clear; out_valid=0, y=0, nx=0.
  - In-flight operations are discarded, with no partial output.
  - in_ready=1 in the cycle after reset deasserts.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, a combinational function of out_valid and out_ready only (no dependency on in_valid).
  - On adv, every stage shifts one step. Stage 0 loads in_valid and operands.
  - On !adv, all stages hold, including bubbles.
- Handshake and latency:
  - A transfer occurs when in_valid && in_ready.
  - With out_ready held high, the result appears with out_valid=1 exactly LATENCY cycles after the accepting edge.
  - Back-to-back throughput is 1 per cycle.
  - Results leave in acceptance order.
  - y and nx are stable while out_valid && !out_ready.
- Sign and magnitude:
  - s = !is_unsigned && x[W-1].
  - m = s ? -x : x, taken as a W-bit unsigned value. Signed minimum -2^(W-1) yields m = 2^(W-1), which is exact.
- Zero: m=0 gives y=0x00000000 (+0.0 for every rm) and nx=0.
- Normalisation:
  - p = index of the leading one of m; biased exponent e = 127+p.
  - If p<=23: mantissa = m<<(23-p), exact, nx=0.
  - Otherwise: keep the top 24 bits; guard = next bit; sticky = OR of all lower bits.
- Rounding increment (lsb = kept lsb, g = guard, st = sticky):
  - RNE: g && (st || lsb).
  - RTZ: 0.
  - RDN: s && (g || st).
  - RUP: !s && (g || st).
  - RMM: g.
  - rm values 101..111 behave as RNE.
  - nx = g || st, regardless of rm.
- Carry: a 24-bit mantissa carry-out sets mantissa to 1.0 and increments e. e never exceeds 127+64, so there is no overflow or infinity path.
- Output packing: y = {s, e[7:0], mantissa[22:0]}. Result is never subnormal or NaN.
- Pipeline partitioning:
  - Stage split is free (leading-one detect, shift, round).
  - LATENCY=1 requires a single-stage registered result.
  - Results must be bit-identical for every LATENCY.
- Simultaneous events:
  - rst overrides all handshakes.
  - out_ready falling while input is offered: in_ready drops the same cycle and the input is not consumed.

Test Plan:
- Zero and sign, W=32, RNE: x=0 gives 0x00000000, nx=0. x=0xFFFFFFFF signed gives 0xBF800000. x=0x80000000 signed gives 0xCF000000, nx=0.
- Rounding, x=0x7FFFFFFF signed:
  - RNE gives 0x4F000000, nx=1.
  - RTZ gives 0x4EFFFFFF, nx=1.
  - RMM gives 0x4F000000.
- Tie and directed modes, x=16777217:
  - RNE gives 0x4B800000 (tie to even).
  - RUP gives 0x4B800001.
  - RDN gives 0x4B800000.
  - x=-16777217 with RDN gives 0xCB800001.
- Unsigned and wide: x=0xFFFFFFFF, is_unsigned=1, RNE gives 0x4F800000, nx=1. W=64, x=2^63 unsigned gives 0x5F000000.
- Backpressure, LATENCY=3, 8 back-to-back operands:
  - out_ready low for 3 cycles mid-stream: in_ready low in the same cycles, y held.
  - All 8 results appear in order, with no loss or duplication.
- Reset mid-flight: rst high for 1 cycle with 2 operations in flight gives out_valid=0 and no stale result afterwards. Compare against a $shortreal-based reference over 1M random operands, all W/LATENCY builds.
